// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package inst_fetch_pkg;

   localparam int          INST_W   = 32;
   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: PC, ROM addressing, decode output stage
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int          ADDR_W   = 5,
   parameter int          DEPTH    = 19,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [31:0]       rom_inst_i,
   input  logic              redirect_valid_i,
   input  logic [31:0]       redirect_pc_i,
   input  logic              id_ready_i,
   output logic              out_valid_o,
   output logic [31:0]       out_pc_o,
   output logic [31:0]       out_inst_o,
   output logic              fault_o,
   output logic [15:0]       fetch_cnt_o
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   fetch_state_e        state_q, state_d;
   logic [31:0]         pc_q, pc_d;
   logic                out_valid_q, out_valid_d;
   logic [31:0]         out_pc_q, out_pc_d;
   logic [INST_W-1:0]   out_inst_q, out_inst_d;
   logic                pc_in_range;

   assign pc_in_range = {2'b00, pc_q[31:2]} < DEPTH_W;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_inst_d  = out_inst_q;
      if (state_q != FAULT) begin
         // Redirect flushes the output stage; a misaligned target faults with pc left untouched.
         if (redirect_valid_i) begin
            out_valid_d = 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
               state_d = FAULT;
            end else begin
               pc_d    = redirect_pc_i;
               state_d = FETCH;
            end
         end else if (state_q == IDLE) begin
            state_d = FETCH;
            if (id_ready_i) out_valid_d = 1'b0;
         end else if (!out_valid_q || id_ready_i) begin
            if (!pc_in_range) begin
               state_d     = FAULT;
               out_valid_d = 1'b0;
            end else begin
               out_valid_d = 1'b1;
               out_pc_d    = pc_q;
               out_inst_d  = rom_inst_i;
               pc_d        = pc_q + PC_STEP;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_pc_q    <= 32'h0;
         out_inst_q  <= NOP_INST;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_inst_q  <= out_inst_d;
      end
   end

   sat_counter #(.WIDTH(16)) u_fetch_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (out_valid_q && id_ready_i),
      .cnt_o (fetch_cnt_o)
   );

   assign rom_addr_o  = pc_q[ADDR_W+1:2];
   assign out_valid_o = out_valid_q;
   assign out_pc_o    = out_pc_q;
   assign out_inst_o  = out_inst_q;
   assign fault_o     = (state_q == FAULT);

endmodule
